bank_conflict_scheduler: RTL and testbench
==========================================

BANK_CONFLICT_SCHEDULER -- requirements
Module: bank_conflict_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 16, SHALL set the full address width per lane.
REQ-003 Parameter Bank_Num_W, default 5, SHALL set the bank-select width; bank = addr[Bank_Num_W-1:0].
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_addr  in  8*ADDR_W  packed lane addresses; lane i = [i*ADDR_W +: ADDR_W].
REQ-007 in_valid  in  8  per-lane request valid.
REQ-008 in_ready  out  8  per-lane accept; transfer when in_valid[i] & in_ready[i].
REQ-009 out_stall  in  1  downstream hazard stage cannot take new reads.
REQ-010 out_addr  out  8*ADDR_W  registered conflict-free lane addresses to the hazard detector read ports.
REQ-011 out_valid  out  8  registered per-lane read valid; no two set lanes share a bank.
REQ-012 conflict_cnt  out  32  stall-statistics counter (see Configuration).

Function
REQ-013 Each lane SHALL hold one pending request (pend[i], paddr[i]).
REQ-014 Arbitration SHALL be combinational over pend: scan lanes from ptr upward mod 8; grant a lane if pending and its bank is not used by an earlier-scanned granted lane.
REQ-015 With out_stall=1, grant SHALL be all-zero.
REQ-016 in_ready[i] SHALL equal ~pend[i] | grant[i]; it SHALL depend only on registered state and out_stall.
REQ-017 On transfer, paddr[i] SHALL load in_addr lane i and pend[i] SHALL set; when granted with no transfer, pend[i] SHALL clear.
REQ-018 Simultaneous grant and transfer on one lane SHALL replace the entry with no bubble.
REQ-019 out_valid[i] SHALL register grant[i] and out_addr lane i SHALL register paddr[i] when granted; latency from accept to out_valid is 1 cycle minimum.
REQ-020 Ungranted lanes SHALL drive out_valid[i]=0; out_addr lane i SHALL hold its previous value.
REQ-021 ptr SHALL advance by 1 mod 8 in any cycle with at least one pending, ungranted lane while out_stall=0; otherwise it holds.
REQ-022 A pending lane SHALL be granted within 8 non-stalled cycles (starvation bound).
REQ-023 No request SHALL be dropped or duplicated, including during out_stall.

Reset
REQ-024 Reset SHALL clear pend, out_valid, out_addr, ptr and conflict_cnt to 0 asynchronously; in-flight pending requests SHALL be discarded.
REQ-025 During reset in_ready SHALL read 8'hFF, but no transfer SHALL be captured.

Configuration
REQ-026 With BCS_STATS_EN defined, conflict_cnt SHALL increment, saturating at 32'hFFFFFFFF, in each cycle REQ-021 advances ptr.
REQ-027 Without BCS_STATS_EN, conflict_cnt SHALL be tied to 0 and the counter SHALL not be synthesized.

Structure
REQ-028 A shared package hdu_pkg SHALL hold LANES=8, default ADDR_W/Bank_Num_W, and the bank-index extraction function.
REQ-029 Grant logic SHALL be the sub-module rr_bank_arbiter (pend, bank vector, ptr, stall -> grant); it SHALL be purely combinational.

Verification
REQ-030 Lanes 0..7 addr 0x0000..0x0007, all valid, ptr=0 -> all accepted; next cycle out_valid=8'hFF, conflict_cnt=0.
REQ-031 Lane0=0x0003, lane1=0x0023 (both bank 3), ptr=0 -> cycle+1 out_valid=8'h01, in_ready[1]=0; cycle+2 out_valid=8'h02; conflict_cnt=1 (macro on).
REQ-032 All lanes bank 5, held valid 8 cycles -> each lane granted exactly once, one-hot out_valid per cycle, ptr advancing.
REQ-033 Four pending lanes, out_stall=1 for 3 cycles -> out_valid=0, in_ready=~pend, ptr frozen; after release all four granted, no loss.
REQ-034 rst pulsed mid-cycle with pend=8'hF0 -> out_valid=0 immediately, pend=0, ptr=0, conflict_cnt=0.

Source files
------------

// File: rtl/hdu_pkg.sv
// rtl/hdu_pkg.sv - shared lane/bank constants, pointer type and bank-index helper
package hdu_pkg;

  localparam int LANES      = 8;
  localparam int PTR_W      = 3;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_BANK_W = 5;

  // Widest address and bank select the helper below accepts.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_BANK_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Bank index is the low bank_w bits of the address; callers truncate to their width.
  function automatic logic [MAX_BANK_W-1:0] bank_idx(input logic [MAX_ADDR_W-1:0] addr,
                                                    input int bank_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << bank_w) - MAX_ADDR_W'(1);
    return MAX_BANK_W'(addr & mask);
  endfunction

endpackage

// File: rtl/rr_bank_arbiter.sv
// rtl/rr_bank_arbiter.sv - combinational rotating-priority grant with per-bank exclusion
module rr_bank_arbiter
  import hdu_pkg::*;
#(
  parameter int BANK_W = DEF_BANK_W
) (
  input  logic [LANES-1:0]        pend,
  input  logic [LANES*BANK_W-1:0] bank,
  input  ptr_t                    ptr,
  input  logic                    stall,
  output logic [LANES-1:0]        grant
);

  localparam int NBANKS = 1 << BANK_W;

  logic [NBANKS-1:0] used;
  logic [BANK_W-1:0] lane_bank;
  ptr_t              lane;

  // Walk lanes starting at ptr; the first pending lane to claim a bank wins it this cycle.
  always_comb begin
    grant     = '0;
    used      = '0;
    lane_bank = '0;
    lane      = ptr;
    for (int k = 0; k < LANES; k++) begin
      lane_bank = bank[int'(lane)*BANK_W +: BANK_W];
      if (!stall && pend[lane] && !used[lane_bank]) begin
        grant[lane]     = 1'b1;
        used[lane_bank] = 1'b1;
      end
      lane = lane + 1'b1;
    end
  end

endmodule

// File: rtl/bank_conflict_scheduler.sv
// rtl/bank_conflict_scheduler.sv - 8-lane bank-conflict-free read scheduler; BCS_STATS_EN enables conflict_cnt
module bank_conflict_scheduler
  import hdu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int Bank_Num_W = DEF_BANK_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*ADDR_W-1:0] in_addr,
  input  logic [LANES-1:0]        in_valid,
  output logic [LANES-1:0]        in_ready,
  input  logic                    out_stall,
  output logic [LANES*ADDR_W-1:0] out_addr,
  output logic [LANES-1:0]        out_valid,
  output logic [31:0]             conflict_cnt
);

  logic [LANES-1:0]            pend_q, pend_d;
  logic [LANES*ADDR_W-1:0]     paddr_q, paddr_d;
  logic [LANES*ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic [LANES-1:0]            out_valid_q, out_valid_d;
  ptr_t                        ptr_q, ptr_d;
  logic [LANES*Bank_Num_W-1:0] bank;
  logic [LANES-1:0]            grant;
  logic [LANES-1:0]            xfer;
  logic                        advance;

  // Bank select of every pending entry, taken from the registered address.
  always_comb begin
    bank = '0;
    for (int i = 0; i < LANES; i++) begin
      bank[i*Bank_Num_W +: Bank_Num_W] =
        Bank_Num_W'(bank_idx(MAX_ADDR_W'(paddr_q[i*ADDR_W +: ADDR_W]), Bank_Num_W));
    end
  end

  rr_bank_arbiter #(
    .BANK_W (Bank_Num_W)
  ) u_arb (
    .pend  (pend_q),
    .bank  (bank),
    .ptr   (ptr_q),
    .stall (out_stall),
    .grant (grant)
  );

  // A lane can accept when empty or when its entry leaves this cycle (no bubble).
  assign in_ready = ~pend_q | grant;
  assign xfer     = in_valid & in_ready;
  // Rotate priority only when someone pending lost out this cycle.
  assign advance  = !out_stall && (|(pend_q & ~grant));

  // Next-state for the pending slots, output stage and priority pointer.
  always_comb begin
    pend_d      = pend_q;
    paddr_d     = paddr_q;
    out_addr_d  = out_addr_q;
    out_valid_d = grant;
    ptr_d       = advance ? ptr_q + 1'b1 : ptr_q;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) begin
        out_addr_d[i*ADDR_W +: ADDR_W] = paddr_q[i*ADDR_W +: ADDR_W];
        pend_d[i]                      = 1'b0;
      end
      if (xfer[i]) begin
        paddr_d[i*ADDR_W +: ADDR_W] = in_addr[i*ADDR_W +: ADDR_W];
        pend_d[i]                   = 1'b1;
      end
    end
  end

  // State registers; reset discards any pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      paddr_q     <= '0;
      out_addr_q  <= '0;
      out_valid_q <= '0;
      ptr_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      paddr_q     <= paddr_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

`ifdef BCS_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  // Count cycles in which a pending lane was held back; saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (advance && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// tb/tb_bank_conflict_scheduler.sv - self-checking bench with reference model for bank_conflict_scheduler
module tb_bank_conflict_scheduler;

  localparam int AW    = 16;
  localparam int BW    = 5;
  localparam int NBANK = 1 << BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [8*AW-1:0] in_addr;
  logic [7:0]    in_valid;
  logic [7:0]    in_ready;
  logic          out_stall;
  logic [8*AW-1:0] out_addr;
  logic [7:0]    out_valid;
  logic [31:0]   conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state, expressed in terms of requests rather than registers.
  bit          m_pend [8];
  logic [15:0] m_addr [8];
  logic [15:0] m_oa   [8];
  logic [7:0]  m_ov;
  int          m_ptr;
  longint      m_cnt;
  logic [15:0] sb [8][$];

  logic [7:0]  g_rdy_obs;
  logic [7:0]  g_xf;

  bank_conflict_scheduler #(.ADDR_W(AW), .Bank_Num_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_addr      (in_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_stall    (out_stall),
    .out_addr     (out_addr),
    .out_valid    (out_valid),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_grant(input logic st);
    logic [7:0] g;
    int used[$];
    bit hit;
    g = 8'h00;
    if (st) return 8'h00;
    for (int k = 0; k < 8; k++) begin
      int lane;
      int b;
      lane = (m_ptr + k) % 8;
      if (m_pend[lane]) begin
        b = int'(m_addr[lane]) % NBANK;
        hit = 1'b0;
        foreach (used[u]) if (used[u] == b) hit = 1'b1;
        if (!hit) begin
          g[lane] = 1'b1;
          used.push_back(b);
        end
      end
    end
    return g;
  endfunction

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 1'b0;
      m_addr[i] = '0;
      m_oa[i]   = '0;
      sb[i].delete();
    end
    m_ov  = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // One clock: apply inputs at negedge, check ready, step the model at posedge, check outputs.
  task automatic cycle(input logic [7:0] v, input logic [8*AW-1:0] a, input logic st);
    logic [7:0]  g, pm, rdy, xf;
    logic [15:0] popped [8];
    bit          adv, clash;
    in_valid  = v;
    in_addr   = a;
    out_stall = st;
    #1;
    g   = model_grant(st);
    pm  = model_pend();
    rdy = ~pm | g;
    xf  = v & rdy;
    g_rdy_obs = in_ready;
    g_xf      = xf;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    #1;
    adv = !st && ((pm & ~g) != 8'h00);
    for (int i = 0; i < 8; i++) begin
      popped[i] = '0;
      if (g[i]) begin
        m_oa[i]   = m_addr[i];
        m_pend[i] = 1'b0;
        if (sb[i].size() > 0) popped[i] = sb[i].pop_front();
      end
      if (xf[i]) begin
        m_pend[i] = 1'b1;
        m_addr[i] = a[i*AW +: AW];
        sb[i].push_back(a[i*AW +: AW]);
      end
    end
    m_ov = g;
    if (adv) begin
      m_ptr = (m_ptr + 1) % 8;
      if (m_cnt != 64'h0000_0000_FFFF_FFFF) m_cnt++;
    end
    chk("out_valid", out_valid, m_ov);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("out_addr[%0d]", i), out_addr[i*AW +: AW], m_oa[i]);
      if (m_ov[i]) chk($sformatf("order[%0d]", i), out_addr[i*AW +: AW], popped[i]);
    end
    clash = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (out_valid[i] && out_valid[j] &&
            (out_addr[i*AW +: BW] == out_addr[j*AW +: BW])) clash = 1'b1;
    chk("bank_unique", clash, 1'b0);
`ifdef BCS_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt[31:0]);
`else
    chk("conflict_cnt", conflict_cnt, 32'd0);
`endif
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle with valid inputs present; outputs must clear at once.
  task automatic do_reset();
    in_valid = 8'hFF;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_in_ready", in_ready, 8'hFF);
    chk("rst_out_addr", out_addr[63:0], 64'h0);
    chk("rst_cnt", conflict_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", in_ready, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [8*AW-1:0] mk_addr(input int base, input int stride);
    logic [8*AW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*AW +: AW] = AW'(base + i * stride);
    return r;
  endfunction

  logic [8*AW-1:0] addr_v;
  logic [7:0]      want;
  int              lane_hits [8];
  int              total;
  int              qleft;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_addr   = '0;
    out_stall = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_out_valid", out_valid, 8'h00);
    chk("reset_in_ready", in_ready, 8'hFF);
    chk("reset_cnt", conflict_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Eight distinct banks, all accepted, all issued together.
    cycle(8'hFF, mk_addr(0, 1), 1'b0);
    chk("d030_accept", g_xf, 8'hFF);
    cycle(8'h00, '0, 1'b0);
    chk("d030_out_valid", out_valid, 8'hFF);
    chk("d030_cnt", conflict_cnt, 32'd0);

    // Two lanes on bank 3: lane 0 first, lane 1 one cycle later.
    addr_v = '0;
    addr_v[0*AW +: AW] = 16'h0003;
    addr_v[1*AW +: AW] = 16'h0023;
    cycle(8'h03, addr_v, 1'b0);
    cycle(8'h00, '0, 1'b0);
    chk("d031_ready1", g_rdy_obs[1], 1'b0);
    chk("d031_ov1", out_valid, 8'h01);
    cycle(8'h00, '0, 1'b0);
    chk("d031_ov2", out_valid, 8'h02);
`ifdef BCS_STATS_EN
    chk("d031_cnt", conflict_cnt, 32'd1);
`endif

    // All lanes on bank 5: each lane issued exactly once, one per cycle.
    addr_v = mk_addr(5, 32);
    want   = 8'hFF;
    total  = 0;
    for (int i = 0; i < 8; i++) lane_hits[i] = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(want, addr_v, 1'b0);
      want = want & ~g_xf;
      chk("d032_onehot", $onehot0(out_valid), 1'b1);
      for (int i = 0; i < 8; i++) if (out_valid[i]) begin
        lane_hits[i]++;
        total++;
      end
    end
    chk("d032_total", total, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("d032_lane%0d", i), lane_hits[i], 1);

    // Four pending lanes held by a stall, then all issued.
    cycle(8'h55, mk_addr(16'h0100, 1), 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(8'h00, '0, 1'b1);
      chk("d033_ov", out_valid, 8'h00);
      chk("d033_ready", g_rdy_obs, 8'hAA);
    end
    cycle(8'h00, '0, 1'b0);
    chk("d033_release", out_valid, 8'h55);

    // Randomized traffic over a few banks to force conflicts.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++)
        addr_v[i*AW +: AW] = (16'($urandom) & 16'hFFE0) | 16'($urandom_range(0, 3));
      cycle(8'($urandom), addr_v, ($urandom_range(0, 4) == 0));
    end
    for (int c = 0; c < 12; c++) cycle(8'h00, '0, 1'b0);
    qleft = 0;
    for (int i = 0; i < 8; i++) qleft += sb[i].size();
    chk("drain_empty", qleft, 0);
    chk("drain_ov", out_valid, 8'h00);

    // Mid-cycle reset with lanes 4..7 pending and issuing.
    cycle(8'hF0, mk_addr(16'h0200, 1), 1'b0);
    cycle(8'hF0, mk_addr(16'h0300, 1), 1'b0);
    chk("d034_pre_ov", out_valid, 8'hF0);
    do_reset();
    cycle(8'h00, '0, 1'b0);
    chk("d034_post_ov", out_valid, 8'h00);
    cycle(8'hFF, mk_addr(16'h0400, 1), 1'b0);
    cycle(8'h00, '0, 1'b0);
    chk("d034_ptr0_ov", out_valid, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
